// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-ported register file: read ports, write ports,
// issue port and the pending-count output.
interface reg_file_mp_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NR    = 2,
  parameter int unsigned NW    = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NR*AW-1:0]   rd_addr;
  logic [NR*XLEN-1:0] rd_data;
  logic [NR-1:0]      rd_ready;
  logic [NW-1:0]      wr_en;
  logic [NW*AW-1:0]   wr_addr;
  logic [NW*XLEN-1:0] wr_data;
  logic               iss_en;
  logic [AW-1:0]      iss_rd;
  logic [AW:0]        busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    input  rd_data, rd_ready, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    output rd_data, rd_ready, busy_cnt
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-ported register file with per-register pending scoreboard and
// optional same-cycle write-to-read bypass.
module reg_file_mp #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NR       = 2,
  parameter int unsigned NW       = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  reg_file_mp_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]    regs [NREGS];
  logic [NREGS-1:0]   pend;
  logic [NREGS-1:0]   pend_nxt;
  logic [CW-1:0]      busy_q;
  logic [CW-1:0]      busy_nxt;
  logic [AW-1:0]      ra;
  logic [NR*XLEN-1:0] rd_data_c;
  logic [NR-1:0]      rd_ready_c;

  // Next pending vector: writes clear, issue sets afterwards so set wins.
  always_comb begin
    pend_nxt = pend;
    busy_nxt = '0;
    for (int j = 0; j < NW; j++) begin
      if (bus.wr_en[j]) pend_nxt[bus.wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (bus.iss_en) pend_nxt[bus.iss_rd] = 1'b1;
    if (ZERO_REG) pend_nxt[0] = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      busy_nxt = busy_nxt + CW'(pend_nxt[k]);
    end
  end

  // Register storage; later ports overwrite earlier ones on an address clash.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (bus.wr_en[j] && !(ZERO_REG && (bus.wr_addr[j*AW +: AW] == '0))) begin
          regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Pending bits and their registered population count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend   <= '0;
      busy_q <= '0;
    end else begin
      pend   <= pend_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Zero-latency read ports: hard-wired zero, then bypass, then stored state.
  always_comb begin
    rd_data_c  = '0;
    rd_ready_c = '1;
    ra         = '0;
    for (int i = 0; i < NR; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      rd_data_c[i*XLEN +: XLEN] = regs[ra];
      rd_ready_c[i]             = ~pend[ra];
      if (BYPASS && reset_n) begin
        for (int j = 0; j < NW; j++) begin
          if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == ra)) begin
            rd_data_c[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
            rd_ready_c[i]             = 1'b1;
          end
        end
      end
      if (ZERO_REG && (ra == '0)) begin
        rd_data_c[i*XLEN +: XLEN] = '0;
        rd_ready_c[i]             = 1'b1;
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_ready = rd_ready_c;
  assign bus.busy_cnt = busy_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: directed stimulus pushes expectations tagged with the
// cycle they apply to; a negedge monitor pops and compares them.
module tb_reg_file_mp;
  localparam int unsigned AW = 5;

  logic clk;
  logic reset_n;
  int unsigned cyc;
  int tests;
  int fails;

  typedef struct {
    int unsigned cyc;
    int          dut;
    bit          is_busy;
    int          port;
    logic [63:0] data;
    logic        ready;
    logic [5:0]  busy;
    string       name;
  } exp_t;

  exp_t q[$];

  reg_file_mp_if #(.XLEN(64), .NREGS(32), .NR(2), .NW(2)) ia ();
  reg_file_mp_if #(.XLEN(64), .NREGS(32), .NR(4), .NW(1)) ib ();

  reg_file_mp #(.XLEN(64), .NREGS(32), .NR(2), .NW(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia)
  );

  reg_file_mp #(.XLEN(64), .NREGS(32), .NR(4), .NW(1), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ib)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at or before this cycle.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [63:0] ad;
    logic        ar;
    logic [5:0]  ab;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.dut == 0) begin
        ad = ia.rd_data[e.port*64 +: 64];
        ar = ia.rd_ready[e.port];
        ab = ia.busy_cnt;
      end else begin
        ad = ib.rd_data[e.port*64 +: 64];
        ar = ib.rd_ready[e.port];
        ab = ib.busy_cnt;
      end
      tests++;
      if (e.is_busy) begin
        if (ab !== e.busy) begin
          fails++;
          $display("FAIL %s: busy_cnt=%0d expected %0d", e.name, ab, e.busy);
        end
      end else if (ad !== e.data || ar !== e.ready) begin
        fails++;
        $display("FAIL %s: port%0d data=%h ready=%b expected data=%h ready=%b",
                 e.name, e.port, ad, ar, e.data, e.ready);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ia.wr_en  = '0;
    ia.iss_en = 1'b0;
    ib.wr_en  = '0;
    ib.iss_en = 1'b0;
  endtask

  task automatic wr(input int d, input int p, input int a, input logic [63:0] v);
    if (d == 0) begin
      ia.wr_en[p]             = 1'b1;
      ia.wr_addr[p*AW +: AW]  = 5'(a);
      ia.wr_data[p*64 +: 64]  = v;
    end else begin
      ib.wr_en[p]             = 1'b1;
      ib.wr_addr[p*AW +: AW]  = 5'(a);
      ib.wr_data[p*64 +: 64]  = v;
    end
  endtask

  task automatic rd(input int d, input int p, input int a);
    if (d == 0) ia.rd_addr[p*AW +: AW] = 5'(a);
    else        ib.rd_addr[p*AW +: AW] = 5'(a);
  endtask

  task automatic iss(input int d, input int a);
    if (d == 0) begin
      ia.iss_en = 1'b1;
      ia.iss_rd = 5'(a);
    end else begin
      ib.iss_en = 1'b1;
      ib.iss_rd = 5'(a);
    end
  endtask

  task automatic chk(input int d, input int p, input logic [63:0] v, input logic r, input string n);
    q.push_back('{cyc, d, 1'b0, p, v, r, 6'd0, n});
  endtask

  task automatic chkb(input int d, input logic [5:0] b, input string n);
    q.push_back('{cyc, d, 1'b1, 0, 64'd0, 1'b0, b, n});
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset_n   = 1'b0;
    ia.rd_addr = '0; ia.wr_en = '0; ia.wr_addr = '0; ia.wr_data = '0;
    ia.iss_en  = 1'b0; ia.iss_rd = '0;
    ib.rd_addr = '0; ib.wr_en = '0; ib.wr_addr = '0; ib.wr_data = '0;
    ib.iss_en  = 1'b0; ib.iss_rd = '0;

    // Reset values
    step();
    rd(0, 0, 5); rd(0, 1, 0); rd(1, 0, 5);
    chk(0, 0, 64'd0, 1'b1, "rst_a_p0");
    chk(0, 1, 64'd0, 1'b1, "rst_a_p1");
    chkb(0, 6'd0, "rst_a_busy");
    chk(1, 0, 64'd0, 1'b1, "rst_b_p0");
    chkb(1, 6'd0, "rst_b_busy");
    step();
    reset_n = 1'b1;

    // T1: data and pending state, then reset asserted mid-operation
    step();
    wr(0, 0, 5, 64'hDEAD); rd(0, 1, 5); iss(0, 6);
    chk(0, 1, 64'hDEAD, 1'b1, "t1_bypass");
    step();
    rd(0, 0, 6);
    chk(0, 1, 64'hDEAD, 1'b1, "t1_stored");
    chk(0, 0, 64'd0, 1'b0, "t1_pend6");
    chkb(0, 6'd1, "t1_busy1");
    step();
    reset_n = 1'b0;
    wr(0, 0, 5, 64'hBEEF); iss(0, 8);
    chk(0, 1, 64'd0, 1'b1, "t1_rst_x5");
    chk(0, 0, 64'd0, 1'b1, "t1_rst_x6");
    chkb(0, 6'd0, "t1_rst_busy");
    step();
    reset_n = 1'b1;
    rd(0, 0, 8);
    chk(0, 1, 64'd0, 1'b1, "t1_lost_wr");
    chk(0, 0, 64'd0, 1'b1, "t1_lost_iss");
    chkb(0, 6'd0, "t1_lost_busy");

    // T2: hard-wired zero register
    step();
    wr(0, 0, 0, 64'hFFFF); iss(0, 0); rd(0, 0, 0);
    chk(0, 0, 64'd0, 1'b1, "t2_x0_same");
    step();
    chk(0, 0, 64'd0, 1'b1, "t2_x0_next");
    chkb(0, 6'd0, "t2_busy");

    // T3: issue then writeback of x7
    step();
    iss(0, 7); rd(0, 0, 7); rd(0, 1, 7);
    chk(0, 0, 64'd0, 1'b1, "t3_pre");
    step();
    chk(0, 0, 64'd0, 1'b0, "t3_pending");
    chkb(0, 6'd1, "t3_busy1");
    step();
    wr(0, 1, 7, 64'h1234);
    chk(0, 0, 64'h1234, 1'b1, "t3_bypass");
    chkb(0, 6'd1, "t3_busy_hold");
    step();
    chk(0, 1, 64'h1234, 1'b1, "t3_stored");
    chkb(0, 6'd0, "t3_busy0");

    // T4: same-address write collision
    step();
    wr(0, 0, 3, 64'hAAAA); wr(0, 1, 3, 64'hBBBB); rd(0, 0, 3);
    chk(0, 0, 64'hBBBB, 1'b1, "t4_bypass");
    step();
    chk(0, 0, 64'hBBBB, 1'b1, "t4_stored");

    // T5: set beats clear, re-issue, pending swap
    step();
    wr(0, 0, 9, 64'h99); iss(0, 9); rd(0, 0, 9);
    chk(0, 0, 64'h99, 1'b1, "t5_bypass");
    step();
    chk(0, 0, 64'h99, 1'b0, "t5_pending");
    chkb(0, 6'd1, "t5_busy");
    step();
    wr(0, 1, 9, 64'h9A); iss(0, 10); rd(0, 1, 10);
    chk(0, 1, 64'd0, 1'b1, "t5_x10_pre");
    chkb(0, 6'd1, "t5_busy_hold");
    step();
    iss(0, 10);
    chk(0, 0, 64'h9A, 1'b1, "t5_clr");
    chk(0, 1, 64'd0, 1'b0, "t5_x10_pend");
    chkb(0, 6'd1, "t5_busy_swap");
    step();
    chkb(0, 6'd1, "t5_reissue");
    iss(0, 11); wr(0, 1, 11, 64'h11); wr(0, 0, 10, 64'h10); rd(0, 0, 11);
    chk(0, 0, 64'h11, 1'b1, "t5_byp_iss11");
    step();
    chk(0, 0, 64'h11, 1'b0, "t5_set_wins");
    chk(0, 1, 64'h10, 1'b1, "t5_x10_done");
    chkb(0, 6'd1, "t5_busy_end");

    // T6: no-bypass build with four read ports and ordinary x0
    step();
    wr(1, 0, 4, 64'h55);
    for (int p = 0; p < 4; p++) begin
      rd(1, p, 4);
      chk(1, p, 64'd0, 1'b1, "t6_same_cycle");
    end
    step();
    for (int p = 0; p < 4; p++) chk(1, p, 64'h55, 1'b1, "t6_next");
    step();
    wr(1, 0, 0, 64'h77); iss(1, 0); rd(1, 0, 0);
    chk(1, 0, 64'd0, 1'b1, "t6_x0_old");
    step();
    chk(1, 0, 64'h77, 1'b0, "t6_x0_pend");
    chkb(1, 6'd1, "t6_busy");

    repeat (3) step();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
